// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register: single outstanding imem fetch, stall/flush/redirect.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        misalign_o
);

`ifdef IF_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HOLD, S_KILL, S_TRAP, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_KILL} state_t;
`endif

  state_t      r_state;
  state_t      w_state_n;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] r_inst;
  logic [31:0] r_pc_o;
  logic        r_valid;
  logic        r_misal;
  logic [31:0] w_redir_pc;
  logic        w_misal;
  logic        w_deliver;
  logic        w_trap_emit;
  logic [31:0] w_deliv_inst;

`ifdef IF_MISALIGN_TRAP_EN
  assign w_redir_pc  = redirect_pc_i;
  assign w_misal     = |redirect_pc_i[1:0];
  assign w_trap_emit = (r_state == S_TRAP) & ~stall_i & ~flush_i & ~redirect_i;
`else
  assign w_redir_pc  = redirect_pc_i & 32'hFFFF_FFFC;
  assign w_misal     = 1'b0;
  assign w_trap_emit = 1'b0;
`endif

  // A word reaches IF/ID either straight from memory or from the stall buffer.
  assign w_deliver    = ~stall_i & ~redirect_i &
                        (((r_state == S_WAIT) & imem_rvalid_i) | (r_state == S_HOLD));
  assign w_deliv_inst = (r_state == S_HOLD) ? r_buf : imem_rdata_i;

  assign imem_req_o  = (r_state == S_IDLE) & ~redirect_i & ~reset_i;
  assign imem_addr_o = r_pc;
  assign inst_o      = r_inst;
  assign pc_o        = r_pc_o;
  assign pc_plus4_o  = r_pc_o + 32'd4;
  assign valid_o     = r_valid;
  assign misalign_o  = r_misal;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  w_state_n = S_WAIT;
      S_WAIT:  if (imem_rvalid_i) w_state_n = stall_i ? S_HOLD : S_IDLE;
      S_HOLD:  if (!stall_i) w_state_n = S_IDLE;
      S_KILL:  if (imem_rvalid_i) w_state_n = S_IDLE;
`ifdef IF_MISALIGN_TRAP_EN
      S_TRAP:  if (w_trap_emit) w_state_n = S_STOP;
`endif
      default: w_state_n = r_state;
    endcase
    // An unanswered fetch must be absorbed in KILL so its late response is not taken as new data.
    if (redirect_i) begin
      if (((r_state == S_WAIT) || (r_state == S_KILL)) && !imem_rvalid_i)
        w_state_n = S_KILL;
      else
        w_state_n = S_IDLE;
`ifdef IF_MISALIGN_TRAP_EN
      if (w_misal) w_state_n = S_TRAP;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_n;
      if (redirect_i)
        r_pc <= w_redir_pc;
      else if (w_deliver)
        r_pc <= r_pc + 32'd4;
      if ((r_state == S_WAIT) && imem_rvalid_i && stall_i && !redirect_i)
        r_buf <= imem_rdata_i;
    end
  end

  // IF/ID register: kill beats hold, hold beats load; an idle cycle inserts a bubble.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_inst  <= NOP_INST;
      r_pc_o  <= '0;
      r_valid <= 1'b0;
      r_misal <= 1'b0;
    end else if (redirect_i || flush_i) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
      r_misal <= 1'b0;
    end else if (!stall_i) begin
      if (w_deliver) begin
        r_inst  <= w_deliv_inst;
        r_pc_o  <= r_pc;
        r_valid <= 1'b1;
        r_misal <= 1'b0;
      end else if (w_trap_emit) begin
        r_inst  <= NOP_INST;
        r_pc_o  <= r_pc;
        r_valid <= 1'b1;
        r_misal <= w_misal | 1'b1;
      end else begin
        r_inst  <= NOP_INST;
        r_valid <= 1'b0;
        r_misal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, hand sequences, randomized run against a queue model.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, flush = 1'b0, redir = 1'b0, rv = 1'b0;
  logic [31:0] rpc = '0, rdata = '0;
  logic        req, vld, mis;
  logic [31:0] addr, inst, pc, pc4;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk_i(clk), .reset_i(rst), .stall_i(stall), .flush_i(flush),
    .redirect_i(redir), .redirect_pc_i(rpc),
    .imem_req_o(req), .imem_addr_o(addr),
    .imem_rvalid_i(rv), .imem_rdata_i(rdata),
    .inst_o(inst), .pc_o(pc), .pc_plus4_o(pc4), .valid_o(vld), .misalign_o(mis)
  );

  typedef struct {
    logic st, fl, rd; logic [31:0] rpc; logic rv; logic [31:0] rdata;
    logic req; logic [31:0] addr; logic vld; logic [31:0] inst; logic [31:0] pc;
  } vec_t;
  vec_t tbl[30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic set_row(input int i, input logic st, input logic fl, input logic rd,
                         input logic [31:0] rp, input logic r, input logic [31:0] rdt,
                         input logic rq, input logic [31:0] ad, input logic v,
                         input logic [31:0] in, input logic [31:0] p);
    tbl[i].st = st; tbl[i].fl = fl; tbl[i].rd = rd; tbl[i].rpc = rp;
    tbl[i].rv = r; tbl[i].rdata = rdt; tbl[i].req = rq; tbl[i].addr = ad;
    tbl[i].vld = v; tbl[i].inst = in; tbl[i].pc = p;
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F1E};
  endfunction

  logic [31:0] ready_q[$];

  initial begin
    logic        busy, req_owed, m_vld, rv_now;
    logic [31:0] exp_req, resp_addr, rv_addr, m_inst, m_pc, a;
    int          resp_at, n_req;

    //          st fl rd rpc           rv rdata          req addr          vld inst          pc
    set_row( 0, 0, 0, 0, 0,            0, 0,             1, 32'h0,         0, NOP,          32'h0);
    set_row( 1, 0, 0, 0, 0,            1, 32'h11,        0, 32'h0,         0, NOP,          32'h0);
    set_row( 2, 0, 0, 0, 0,            0, 0,             1, 32'h4,         1, 32'h11,       32'h0);
    set_row( 3, 0, 0, 0, 0,            1, 32'h22,        0, 32'h4,         0, NOP,          32'h0);
    set_row( 4, 1, 0, 0, 0,            0, 0,             1, 32'h8,         1, 32'h22,       32'h4);
    set_row( 5, 1, 0, 0, 0,            1, 32'h00500093,  0, 32'h8,         1, 32'h22,       32'h4);
    set_row( 6, 1, 0, 0, 0,            0, 0,             0, 32'h8,         1, 32'h22,       32'h4);
    set_row( 7, 0, 0, 0, 0,            0, 0,             0, 32'h8,         1, 32'h22,       32'h4);
    set_row( 8, 0, 1, 0, 0,            0, 0,             1, 32'hC,         1, 32'h00500093, 32'h8);
    set_row( 9, 0, 0, 0, 0,            1, 32'h33,        0, 32'hC,         0, NOP,          32'h8);
    set_row(10, 0, 0, 0, 0,            0, 0,             1, 32'h10,        1, 32'h33,       32'hC);
    set_row(11, 0, 0, 1, 32'h100,      0, 0,             0, 32'h10,        0, NOP,          32'hC);
    set_row(12, 0, 0, 0, 0,            0, 0,             0, 32'h100,       0, NOP,          32'hC);
    set_row(13, 0, 0, 0, 0,            1, 32'hDEAD,      0, 32'h100,       0, NOP,          32'hC);
    set_row(14, 0, 0, 0, 0,            0, 0,             1, 32'h100,       0, NOP,          32'hC);
    set_row(15, 0, 0, 0, 0,            1, 32'h44,        0, 32'h100,       0, NOP,          32'hC);
    set_row(16, 0, 0, 1, 32'hFFFFFFFC, 0, 0,             0, 32'h104,       1, 32'h44,       32'h100);
    set_row(17, 0, 0, 0, 0,            0, 0,             1, 32'hFFFFFFFC,  0, NOP,          32'h100);
    set_row(18, 0, 0, 0, 0,            1, 32'h55,        0, 32'hFFFFFFFC,  0, NOP,          32'h100);
    set_row(19, 0, 0, 0, 0,            0, 0,             1, 32'h0,         1, 32'h55,       32'hFFFFFFFC);
    set_row(20, 0, 0, 0, 0,            1, 32'h66,        0, 32'h0,         0, NOP,          32'hFFFFFFFC);
    set_row(21, 0, 0, 0, 0,            0, 0,             1, 32'h4,         1, 32'h66,       32'h0);
    set_row(22, 0, 0, 1, 32'h200,      1, 32'h77,        0, 32'h4,         0, NOP,          32'h0);
    set_row(23, 0, 0, 0, 0,            0, 0,             1, 32'h200,       0, NOP,          32'h0);
    set_row(24, 1, 0, 0, 0,            1, 32'h88,        0, 32'h200,       0, NOP,          32'h0);
    set_row(25, 0, 0, 1, 32'h300,      0, 0,             0, 32'h200,       0, NOP,          32'h0);
    set_row(26, 0, 0, 0, 0,            0, 0,             1, 32'h300,       0, NOP,          32'h0);
    set_row(27, 0, 0, 0, 0,            1, 32'h99,        0, 32'h300,       0, NOP,          32'h0);
    set_row(28, 0, 0, 0, 0,            0, 0,             1, 32'h304,       1, 32'h99,       32'h300);
    set_row(29, 0, 0, 0, 0,            1, 32'hAA,        0, 32'h304,       0, NOP,          32'h300);

    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h4);
    chk("rst_valid", {31'b0, vld}, 32'd0);
    chk("rst_misalign", {31'b0, mis}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      stall = tbl[i].st; flush = tbl[i].fl; redir = tbl[i].rd; rpc = tbl[i].rpc;
      rv = tbl[i].rv; rdata = tbl[i].rdata;
      #1;
      chk($sformatf("row%0d_req", i), {31'b0, req}, {31'b0, tbl[i].req});
      chk($sformatf("row%0d_addr", i), addr, tbl[i].addr);
      chk($sformatf("row%0d_valid", i), {31'b0, vld}, {31'b0, tbl[i].vld});
      chk($sformatf("row%0d_inst", i), inst, tbl[i].inst);
      chk($sformatf("row%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("row%0d_pc4", i), pc4, tbl[i].pc + 32'd4);
      chk($sformatf("row%0d_misalign", i), {31'b0, mis}, 32'd0);
      adv();
    end
    stall = 0; flush = 0; redir = 0; rv = 0;

`ifdef IF_MISALIGN_TRAP_EN
    redir = 1; rpc = 32'h102; #1;
    chk("trap_noreq0", {31'b0, req}, 32'd0);
    adv(); redir = 0; #1;
    chk("trap_noreq1", {31'b0, req}, 32'd0);
    chk("trap_mis_pre", {31'b0, mis}, 32'd0);
    adv(); #1;
    chk("trap_noreq2", {31'b0, req}, 32'd0);
    chk("trap_valid", {31'b0, vld}, 32'd1);
    chk("trap_misalign", {31'b0, mis}, 32'd1);
    chk("trap_pc", pc, 32'h102);
    chk("trap_inst", inst, NOP);
    adv(); redir = 1; rpc = 32'h200; #1;
    chk("stop_noreq", {31'b0, req}, 32'd0);
    adv(); redir = 0; #1;
    chk("resume_req", {31'b0, req}, 32'd1);
    chk("resume_addr", addr, 32'h200);
    chk("resume_mis", {31'b0, mis}, 32'd0);
    adv(); rv = 1; rdata = 32'hBB;
    adv(); rv = 0; #1;
    chk("resume_valid", {31'b0, vld}, 32'd1);
    chk("resume_inst", inst, 32'hBB);
    chk("resume_pc", pc, 32'h200);
    m_pc = 32'h200;
`else
    redir = 1; rpc = 32'h402; #1;
    chk("misredir_noreq", {31'b0, req}, 32'd0);
    adv(); redir = 0; #1;
    chk("misredir_req", {31'b0, req}, 32'd1);
    chk("misredir_addr", addr, 32'h400);
    chk("misredir_mis", {31'b0, mis}, 32'd0);
    adv(); rv = 1; rdata = 32'hBB;
    adv(); rv = 0; #1;
    chk("misredir_valid", {31'b0, vld}, 32'd1);
    chk("misredir_inst", inst, 32'hBB);
    chk("misredir_pc", pc, 32'h400);
    m_pc = 32'h400;
`endif

    // Randomized run: stalls and memory latency vary; the model only tracks ready words in order.
    busy = 0; req_owed = 1; m_vld = 1; m_inst = 32'hBB; exp_req = m_pc + 32'd4;
    resp_at = 0; resp_addr = '0; n_req = 0;
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 2) == 0);
      rv_now = busy && (c == resp_at);
      rv_addr = resp_addr;
      if (rv_now) begin
        rv = 1; rdata = memw(resp_addr); busy = 0;
      end else begin
        rv = 0; rdata = $urandom;
      end
      #1;
      chk("rnd_valid", {31'b0, vld}, {31'b0, m_vld});
      chk("rnd_inst", inst, m_inst);
      chk("rnd_pc", pc, m_pc);
      if (req_owed) chk("rnd_req_due", {31'b0, req}, 32'd1);
      if (req) begin
        chk("rnd_single_outstanding", {31'b0, busy}, 32'd0);
        chk("rnd_addr", addr, exp_req);
        resp_addr = exp_req;
        exp_req += 32'd4;
        busy = 1;
        resp_at = c + $urandom_range(1, 4);
        n_req++;
      end
      req_owed = 0;
      if (rv_now) ready_q.push_back(rv_addr);
      if (!stall) begin
        if (ready_q.size() > 0) begin
          a = ready_q.pop_front();
          m_vld = 1; m_inst = memw(a); m_pc = a; req_owed = 1;
        end else begin
          m_vld = 0; m_inst = NOP;
        end
      end
      adv();
    end
    chk("rnd_progress", {31'b0, n_req > 60}, 32'd1);

    stall = 0; rv = 0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, vld}, 32'd0);
    chk("async_rst_inst", inst, NOP);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_req", {31'b0, req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req", {31'b0, req}, 32'd1);
    chk("post_rst_addr", addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
